// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path:
//   SEG_TABLE   - active-high {a,b,c,d,e,f,g} patterns for hex digits 0..F
//   SEG_OFF     - active-low "all segments dark" value
//   slot_state_e- per-slot FSM states of the multiplexing driver
//   hex_pattern - table lookup helper
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } slot_state_e;

   // Index 15 is leftmost in the concatenation, index 0 rightmost.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b1000111,  // F
      7'b1001111,  // E
      7'b0111101,  // d
      7'b1001110,  // C
      7'b0011111,  // b
      7'b1110111,  // A
      7'b1111011,  // 9
      7'b1111111,  // 8
      7'b1110000,  // 7
      7'b1011111,  // 6
      7'b1011011,  // 5
      7'b0110011,  // 4
      7'b1111001,  // 3
      7'b1101101,  // 2
      7'b0110000,  // 1
      7'b1111110   // 0
   };

   function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   nibble  in  4  hex value 0..F
//   pattern out 7  active-high {a,b,c,d,e,f,g}, pattern[6] = a
// -----------------------------------------------------------------------------
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = hex_pattern(nibble);

endmodule

// File: rtl/seg7_mux_driver.sv
// -----------------------------------------------------------------------------
// seg7_mux_driver
// Time-multiplexed common-anode seven-segment driver for NUM_DIGITS digits.
// Each digit slot lasts REFRESH_DIV cycles: BLANK_CYCLES with all anodes off
// (anti-ghosting), then the digit is driven. New data is captured on `load`
// into a pending register and only copied to the displayed register at the
// frame boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   data_in        in   hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in          in   decimal point enables, bit i -> digit i (1 = lit)
//   lz_suppress    in   1 = blank leading zero digits (sampled live)
//   load           in   single-cycle capture strobe for data_in/dp_in
//   an             out  anode enables, active low
//   seg            out  segments {a..g}, active low
//   dp             out  decimal point, active low
//   digit_idx      out  index of the active digit slot
//   update_pending out  captured data not yet on display
//   frame_done     out  one-cycle pulse at the end of the last digit slot
// -----------------------------------------------------------------------------
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      lz_suppress,
   input  logic                      load,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [2:0]                digit_idx,
   output logic                      update_pending,
   output logic                      frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST       = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]             cnt_q, cnt_d;
   slot_state_e                  state_q, state_d;
   logic [2:0]                   slot_q, slot_d;
   logic [NUM_DIGITS-1:0][3:0]   disp_data_q, disp_data_d;
   logic [NUM_DIGITS-1:0]        disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0][3:0]   pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0]        pend_dp_q, pend_dp_d;
   logic                         upd_q, upd_d;
   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic [6:0]                   seg_q, seg_d;
   logic                         dp_q, dp_d;
   logic [2:0]                   digit_idx_q, digit_idx_d;
   logic                         frame_done_q, frame_done_d;

   logic [SEL_W-1:0]             sel;
   logic [6:0]                   pattern;
   logic [NUM_DIGITS-1:0]        lz_blank;
   logic                         zero_above;
   logic                         slot_end;
   logic                         boundary;

   assign sel = slot_q[SEL_W-1:0];

   hex_to_seg7 u_dec (
      .nibble  (disp_data_q[sel]),
      .pattern (pattern)
   );

   // A digit is a leading zero when it and every more-significant digit
   // are zero; digit 0 is never suppressed so "0" still shows.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update,
      // otherwise the synthesiser infers a latch to hold the old value.
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above  = zero_above & (disp_data_q[i] == 4'h0);
         lz_blank[i] = zero_above && (i != 0);
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      state_d      = state_q;
      slot_d       = slot_q;
      disp_data_d  = disp_data_q;
      disp_dp_d    = disp_dp_q;
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      upd_d        = upd_q;

      slot_end = (cnt_q == CNT_LAST);
      boundary = slot_end && (slot_q == IDX_LAST);

      // Slot timing: counter and state always describe the same cycle.
      if (slot_end) begin
         cnt_d   = '0;
         state_d = BLANK;
         slot_d  = (slot_q == IDX_LAST) ? 3'd0 : slot_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
      end

      // Load handshake; a load landing on the boundary bypasses pending.
      if (load) begin
         pend_data_d = data_in;
         pend_dp_d   = dp_in;
      end
      if (boundary) begin
         if (load) begin
            disp_data_d = data_in;
            disp_dp_d   = dp_in;
         end else if (upd_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
         end
         upd_d = 1'b0;
      end else if (load) begin
         upd_d = 1'b1;
      end

      // Registered outputs reflect the slot described by cnt_q/slot_q.
      an_d         = '1;
      seg_d        = SEG_OFF;
      dp_d         = 1'b1;
      if (state_q == DRIVE) begin
         an_d[sel] = 1'b0;
         seg_d     = (lz_suppress && lz_blank[sel]) ? SEG_OFF : ~pattern;
         dp_d      = ~disp_dp_q[sel];
      end
      digit_idx_d  = slot_q;
      frame_done_d = boundary;
   end

   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         state_q      <= BLANK;
         slot_q       <= 3'd0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         upd_q        <= 1'b0;
         an_q         <= '1;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         digit_idx_q  <= 3'd0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         slot_q       <= slot_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         upd_q        <= upd_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         digit_idx_q  <= digit_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an             = an_q;
   assign seg            = seg_q;
   assign dp             = dp_q;
   assign digit_idx      = digit_idx_q;
   assign update_pending = upd_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_mux_driver
// Directed bench for seg7_mux_driver: a 4-digit instance and an 8-digit
// instance, both with REFRESH_DIV=8 and BLANK_CYCLES=2 (8-cycle slots).
// "Cycle k" is the output state after the k-th rising edge with reset low.
// -----------------------------------------------------------------------------
module tb_seg7_mux_driver;

   typedef struct {
      int          cyc;
      logic        ld;
      logic [31:0] data;
      logic [7:0]  dpv;
      logic        lz;
   } stim_t;

   typedef struct {
      int          cyc;
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic [2:0]  idx;
      logic        upd;
      logic        fd;
   } chk_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-digit instance
   logic        reset4 = 1'b1;
   logic [15:0] data4  = '0;
   logic [3:0]  dp4    = '0;
   logic        lz4    = 1'b0;
   logic        load4  = 1'b0;
   logic [3:0]  an4;
   logic [6:0]  seg4;
   logic        dpo4, upd4, fd4;
   logic [2:0]  idx4;

   // 8-digit instance
   logic        reset8 = 1'b1;
   logic [31:0] data8  = '0;
   logic [7:0]  dp8    = '0;
   logic        lz8    = 1'b0;
   logic        load8  = 1'b0;
   logic [7:0]  an8;
   logic [6:0]  seg8;
   logic        dpo8, upd8, fd8;
   logic [2:0]  idx8;

   seg7_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut4 (
      .clk            (clk),
      .reset          (reset4),
      .data_in        (data4),
      .dp_in          (dp4),
      .lz_suppress    (lz4),
      .load           (load4),
      .an             (an4),
      .seg            (seg4),
      .dp             (dpo4),
      .digit_idx      (idx4),
      .update_pending (upd4),
      .frame_done     (fd4)
   );

   seg7_mux_driver #(.NUM_DIGITS(8), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut8 (
      .clk            (clk),
      .reset          (reset8),
      .data_in        (data8),
      .dp_in          (dp8),
      .lz_suppress    (lz8),
      .load           (load8),
      .an             (an8),
      .seg            (seg8),
      .dp             (dpo8),
      .digit_idx      (idx8),
      .update_pending (upd8),
      .frame_done     (fd8)
   );

   int n_checks = 0;
   int n_errors = 0;

   stim_t s_q[$];
   chk_t  v_q[$];

   task automatic check(input string name, input int cyc,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_s(input int cyc, input logic ld, input logic [31:0] data,
                        input logic [7:0] dpv, input logic lz);
      stim_t s;
      s.cyc = cyc; s.ld = ld; s.data = data; s.dpv = dpv; s.lz = lz;
      s_q.push_back(s);
   endtask

   task automatic add_c(input int cyc, input logic [7:0] an, input logic [6:0] seg,
                        input logic dp, input logic [2:0] idx, input logic upd,
                        input logic fd);
      chk_t c;
      c.cyc = cyc; c.an = an; c.seg = seg; c.dp = dp;
      c.idx = idx; c.upd = upd; c.fd = fd;
      v_q.push_back(c);
   endtask

   // Applies s_q and compares v_q on the 4-digit instance, cycles 0..last.
   // With fd_scan set, frame_done is also checked every cycle of frame 0.
   task automatic run4(input int last, input bit fd_scan);
      for (int c = 0; c <= last; c++) begin
         load4 = 1'b0;
         foreach (s_q[k]) if (s_q[k].cyc == c) begin
            load4 = s_q[k].ld;
            data4 = s_q[k].data[15:0];
            dp4   = s_q[k].dpv[3:0];
            lz4   = s_q[k].lz;
         end
         step();
         load4 = 1'b0;
         if (fd_scan && c < 32) check("fd_scan", c, 32'(fd4), 32'(c == 31));
         foreach (v_q[k]) if (v_q[k].cyc == c) begin
            check("an4",  c, 32'(an4),  32'(v_q[k].an[3:0]));
            check("seg4", c, 32'(seg4), 32'(v_q[k].seg));
            check("dp4",  c, 32'(dpo4), 32'(v_q[k].dp));
            check("idx4", c, 32'(idx4), 32'(v_q[k].idx));
            check("upd4", c, 32'(upd4), 32'(v_q[k].upd));
            check("fd4",  c, 32'(fd4),  32'(v_q[k].fd));
         end
      end
   endtask

   task automatic run8(input int last);
      for (int c = 0; c <= last; c++) begin
         load8 = 1'b0;
         foreach (s_q[k]) if (s_q[k].cyc == c) begin
            load8 = s_q[k].ld;
            data8 = s_q[k].data;
            dp8   = s_q[k].dpv;
            lz8   = s_q[k].lz;
         end
         step();
         load8 = 1'b0;
         foreach (v_q[k]) if (v_q[k].cyc == c) begin
            check("an8",  c, 32'(an8),  32'(v_q[k].an));
            check("seg8", c, 32'(seg8), 32'(v_q[k].seg));
            check("dp8",  c, 32'(dpo8), 32'(v_q[k].dp));
            check("idx8", c, 32'(idx8), 32'(v_q[k].idx));
            check("upd8", c, 32'(upd8), 32'(v_q[k].upd));
            check("fd8",  c, 32'(fd8),  32'(v_q[k].fd));
         end
      end
   endtask

   initial begin
      // ---------------- 4-digit instance: frames 0..6 ----------------
      // loads: A194/dp 0010, 0050 + lz, 0000, lz off, 1111 then 2222,
      // 3333 coincident with the boundary, 4444 before a mid-frame reset.
      add_s(3,   1'b1, 32'h0000_A194, 8'h02, 1'b0);
      add_s(40,  1'b1, 32'h0000_0050, 8'h00, 1'b1);
      add_s(70,  1'b1, 32'h0000_0000, 8'h00, 1'b1);
      add_s(124, 1'b0, 32'h0000_0000, 8'h00, 1'b0);
      add_s(130, 1'b1, 32'h0000_1111, 8'h00, 1'b0);
      add_s(140, 1'b1, 32'h0000_2222, 8'h00, 1'b0);
      add_s(191, 1'b1, 32'h0000_3333, 8'h0F, 1'b0);
      add_s(200, 1'b1, 32'h0000_4444, 8'h00, 1'b0);

      //    cyc  an     seg    dp    idx   upd   fd
      add_c(0,   8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(1,   8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(2,   8'hE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(3,   8'hE, 7'h01, 1'b1, 3'd0, 1'b1, 1'b0);
      add_c(7,   8'hE, 7'h01, 1'b1, 3'd0, 1'b1, 1'b0);
      add_c(8,   8'hF, 7'h7F, 1'b1, 3'd1, 1'b1, 1'b0);
      add_c(10,  8'hD, 7'h01, 1'b1, 3'd1, 1'b1, 1'b0);
      add_c(30,  8'h7, 7'h01, 1'b1, 3'd3, 1'b1, 1'b0);
      add_c(31,  8'h7, 7'h01, 1'b1, 3'd3, 1'b0, 1'b1);
      add_c(32,  8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(34,  8'hE, 7'h4C, 1'b1, 3'd0, 1'b0, 1'b0);  // "4"
      add_c(42,  8'hD, 7'h04, 1'b0, 3'd1, 1'b1, 1'b0);  // "9." (0050 pending)
      add_c(50,  8'hB, 7'h4F, 1'b1, 3'd2, 1'b1, 1'b0);  // "1"
      add_c(58,  8'h7, 7'h08, 1'b1, 3'd3, 1'b1, 1'b0);  // "A"
      add_c(63,  8'h7, 7'h08, 1'b1, 3'd3, 1'b0, 1'b1);
      add_c(66,  8'hE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);  // "0"
      add_c(74,  8'hD, 7'h24, 1'b1, 3'd1, 1'b1, 1'b0);  // "5"
      add_c(82,  8'hB, 7'h7F, 1'b1, 3'd2, 1'b1, 1'b0);  // suppressed
      add_c(90,  8'h7, 7'h7F, 1'b1, 3'd3, 1'b1, 1'b0);  // suppressed
      add_c(95,  8'h7, 7'h7F, 1'b1, 3'd3, 1'b0, 1'b1);
      add_c(98,  8'hE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);  // 0000: digit0 lit
      add_c(106, 8'hD, 7'h7F, 1'b1, 3'd1, 1'b0, 1'b0);
      add_c(114, 8'hB, 7'h7F, 1'b1, 3'd2, 1'b0, 1'b0);
      add_c(122, 8'h7, 7'h7F, 1'b1, 3'd3, 1'b0, 1'b0);
      add_c(124, 8'h7, 7'h01, 1'b1, 3'd3, 1'b0, 1'b0);  // lz dropped live
      add_c(130, 8'hE, 7'h01, 1'b1, 3'd0, 1'b1, 1'b0);
      add_c(140, 8'hD, 7'h01, 1'b1, 3'd1, 1'b1, 1'b0);
      add_c(159, 8'h7, 7'h01, 1'b1, 3'd3, 1'b0, 1'b1);
      add_c(160, 8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(162, 8'hE, 7'h12, 1'b1, 3'd0, 1'b0, 1'b0);  // "2", never "1"
      add_c(186, 8'h7, 7'h12, 1'b1, 3'd3, 1'b0, 1'b0);
      add_c(191, 8'h7, 7'h12, 1'b1, 3'd3, 1'b0, 1'b1);  // bypass load
      add_c(192, 8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(194, 8'hE, 7'h06, 1'b0, 3'd0, 1'b0, 1'b0);  // "3."
      add_c(200, 8'hF, 7'h7F, 1'b1, 3'd1, 1'b1, 1'b0);
      add_c(202, 8'hD, 7'h06, 1'b0, 3'd1, 1'b1, 1'b0);
      add_c(211, 8'hB, 7'h06, 1'b0, 3'd2, 1'b1, 1'b0);  // driving digit 2

      repeat (5) step();
      reset4 = 1'b0;
      run4(211, 1'b1);

      // ---------------- reset during DRIVE of digit 2 ----------------
      reset4 = 1'b1;
      step();
      check("rst_an",  -1, 32'(an4),  32'hF);
      check("rst_seg", -1, 32'(seg4), 32'h7F);
      check("rst_dp",  -1, 32'(dpo4), 32'h1);
      check("rst_idx", -1, 32'(idx4), 32'h0);
      check("rst_upd", -1, 32'(upd4), 32'h0);
      check("rst_fd",  -1, 32'(fd4),  32'h0);
      step();
      step();
      reset4 = 1'b0;
      s_q.delete();
      v_q.delete();
      add_c(1,  8'hF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(2,  8'hE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(10, 8'hD, 7'h01, 1'b1, 3'd1, 1'b0, 1'b0);
      add_c(26, 8'h7, 7'h01, 1'b1, 3'd3, 1'b0, 1'b0);
      add_c(31, 8'h7, 7'h01, 1'b1, 3'd3, 1'b0, 1'b1);
      add_c(34, 8'hE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);  // 4444 discarded
      run4(34, 1'b0);

      // ---------------- 8-digit instance: all 16 patterns ----------------
      s_q.delete();
      v_q.delete();
      add_s(3,  1'b1, 32'hFEDC_BA98, 8'hA5, 1'b0);
      add_s(70, 1'b1, 32'h7654_3210, 8'h00, 1'b0);

      add_c(0,   8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(2,   8'hFE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(3,   8'hFE, 7'h01, 1'b1, 3'd0, 1'b1, 1'b0);
      add_c(63,  8'h7F, 7'h01, 1'b1, 3'd7, 1'b0, 1'b1);
      add_c(64,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);  // wrap 7 -> 0
      add_c(66,  8'hFE, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0);  // "8."
      add_c(74,  8'hFD, 7'h04, 1'b1, 3'd1, 1'b1, 1'b0);  // "9"
      add_c(82,  8'hFB, 7'h08, 1'b0, 3'd2, 1'b1, 1'b0);  // "A."
      add_c(90,  8'hF7, 7'h60, 1'b1, 3'd3, 1'b1, 1'b0);  // "b"
      add_c(98,  8'hEF, 7'h31, 1'b1, 3'd4, 1'b1, 1'b0);  // "C"
      add_c(106, 8'hDF, 7'h42, 1'b0, 3'd5, 1'b1, 1'b0);  // "d."
      add_c(114, 8'hBF, 7'h30, 1'b1, 3'd6, 1'b1, 1'b0);  // "E"
      add_c(122, 8'h7F, 7'h38, 1'b0, 3'd7, 1'b1, 1'b0);  // "F."
      add_c(127, 8'h7F, 7'h38, 1'b0, 3'd7, 1'b0, 1'b1);
      add_c(128, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, 1'b0);
      add_c(130, 8'hFE, 7'h01, 1'b1, 3'd0, 1'b0, 1'b0);  // "0"
      add_c(138, 8'hFD, 7'h4F, 1'b1, 3'd1, 1'b0, 1'b0);  // "1"
      add_c(146, 8'hFB, 7'h12, 1'b1, 3'd2, 1'b0, 1'b0);  // "2"
      add_c(154, 8'hF7, 7'h06, 1'b1, 3'd3, 1'b0, 1'b0);  // "3"
      add_c(162, 8'hEF, 7'h4C, 1'b1, 3'd4, 1'b0, 1'b0);  // "4"
      add_c(170, 8'hDF, 7'h24, 1'b1, 3'd5, 1'b0, 1'b0);  // "5"
      add_c(178, 8'hBF, 7'h20, 1'b1, 3'd6, 1'b0, 1'b0);  // "6"
      add_c(186, 8'h7F, 7'h0F, 1'b1, 3'd7, 1'b0, 1'b0);  // "7"

      repeat (3) step();
      reset8 = 1'b0;
      run8(186);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
